// File: rtl/proc_rr_arbiter_if.sv
// Bundle between the requester/resource side and proc_rr_arbiter.
// The master modport is the requester/resource side: it drives req and res_done.
// The slave modport is the arbiter: it drives grant, status and completion signals.
interface proc_rr_arbiter_if #(
  parameter int unsigned NREQ = 4
);
  localparam int unsigned OW = $clog2(NREQ);

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [OW-1:0]   owner;
  logic            busy;
  logic            res_start;
  logic            res_done;
  logic [NREQ-1:0] ack;
  logic            tmo;

  modport master (
    output req,
    output res_done,
    input  gnt,
    input  owner,
    input  busy,
    input  res_start,
    input  ack,
    input  tmo
  );

  modport slave (
    input  req,
    input  res_done,
    output gnt,
    output owner,
    output busy,
    output res_start,
    output ack,
    output tmo
  );
endinterface

// File: rtl/proc_rr_arbiter.sv
// Round-robin arbiter/sequencer sharing one start/done processing resource among NREQ
// requesters. Each transaction: grant one requester, pulse res_start, wait for res_done
// or a timeout of TMO_CYC wait cycles, pulse ack (or tmo) and rotate priority past the
// owner. Every output is registered.
//
// Optional: define PROC_RR_ARBITER_SVA_EN to compile protocol assertions and covers.
// Without it the module contains no assertion code and behaves identically.
module proc_rr_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TMO_CYC = 15
) (
  input logic               clk,
  input logic               rst_n,
  proc_rr_arbiter_if.slave  bus_io
);

  localparam int unsigned OW = $clog2(NREQ);
  // TMO_CYC is at most 255, so an 8-bit wait counter always suffices.
  localparam int unsigned CW = 8;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StGrant   = 2'd1;
  localparam logic [1:0] StWait    = 2'd2;
  localparam logic [1:0] StRelease = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [OW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic            busy_q, busy_d;
  logic            res_start_q, res_start_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            tmo_q, tmo_d;

  // Round-robin pick
  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic              sel_vld;
  logic [OW-1:0]     sel;
  int unsigned       first;
  int unsigned       sel_sum;
  logic [OW-1:0]     ptr_nxt;

  // Rotate requests so bit 0 is the highest-priority requester, then find the first set bit.
  always_comb begin
    req_dbl = {bus_io.req, bus_io.req};
    req_rot = NREQ'(req_dbl >> ptr_q);
    sel_vld = |req_rot;
    first   = 0;
    for (int unsigned k = NREQ; k > 0; k--) begin
      if (req_rot[k-1]) begin
        first = k - 1;
      end
    end
    sel_sum = 32'(ptr_q) + first;
    if (sel_sum >= NREQ) begin
      sel_sum = sel_sum - NREQ;
    end
    sel = OW'(sel_sum);
  end

  // Priority moves to the requester just after the one being released, wrapping at NREQ.
  always_comb begin
    if (owner_q == OW'(NREQ - 1)) begin
      ptr_nxt = '0;
    end else begin
      ptr_nxt = owner_q + 1'b1;
    end
  end

  // Transaction sequencing and next values of all registered outputs.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    owner_d     = owner_q;
    res_start_d = 1'b0;
    ack_d       = '0;
    tmo_d       = 1'b0;

    case (state_q)
      StIdle: begin
        if (sel_vld) begin
          state_d     = StGrant;
          gnt_d       = {{(NREQ-1){1'b0}}, 1'b1} << sel;
          owner_d     = sel;
          res_start_d = 1'b1;
        end
      end
      StGrant: begin
        // res_done is deliberately not looked at until WAIT.
        state_d = StWait;
        cnt_d   = '0;
      end
      StWait: begin
        // A done on the last allowed cycle beats the timeout.
        if (bus_io.res_done) begin
          state_d = StRelease;
          gnt_d   = '0;
          ack_d   = gnt_q;
        end else if (cnt_q == CW'(TMO_CYC - 1)) begin
          state_d = StRelease;
          gnt_d   = '0;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRelease: begin
        state_d = StIdle;
        ptr_d   = ptr_nxt;
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  // State and output registers; synchronous reset abandons any transaction silently.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      owner_q     <= '0;
      busy_q      <= 1'b0;
      res_start_q <= 1'b0;
      ack_q       <= '0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      owner_q     <= owner_d;
      busy_q      <= busy_d;
      res_start_q <= res_start_d;
      ack_q       <= ack_d;
      tmo_q       <= tmo_d;
    end
  end

  assign bus_io.gnt       = gnt_q;
  assign bus_io.owner     = owner_q;
  assign bus_io.busy      = busy_q;
  assign bus_io.res_start = res_start_q;
  assign bus_io.ack       = ack_q;
  assign bus_io.tmo       = tmo_q;

`ifdef PROC_RR_ARBITER_SVA_EN
  a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(bus_io.gnt));

  a_start_pulse: assert property (@(posedge clk) disable iff (!rst_n)
    bus_io.res_start |=> !bus_io.res_start);

  a_done_after_busy: assert property (@(posedge clk) disable iff (!rst_n)
    ((bus_io.ack != '0) || bus_io.tmo) |-> $past(bus_io.busy));

  a_ack_tmo_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !((bus_io.ack != '0) && bus_io.tmo));

  a_tmo_at_limit: assert property (@(posedge clk) disable iff (!rst_n)
    bus_io.tmo |-> $past((state_q == StWait) && (cnt_q == CW'(TMO_CYC - 1))));

  // Requester side: a granted request must stay up until ack or tmo.
  for (genvar i = 0; i < NREQ; i++) begin : g_req_hold
    a_req_held: assert property (@(posedge clk) disable iff (!rst_n)
      bus_io.gnt[i] |-> bus_io.req[i]);
  end

  c_timeout: cover property (@(posedge clk) disable iff (!rst_n) bus_io.tmo);

  c_ptr_wrap: cover property (@(posedge clk) disable iff (!rst_n)
    (ptr_q == OW'(NREQ - 1)) ##1 (ptr_q == '0));

  c_done_last: cover property (@(posedge clk) disable iff (!rst_n)
    (state_q == StWait) && bus_io.res_done && (cnt_q == CW'(TMO_CYC - 1)));
`endif

endmodule
